// File: rtl/master_interface.sv
// master_interface: transmit side of the valid/ready link.
// Buffers producer words in a small FIFO and presents them to the slave.
module master_interface #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_master_en,
    input  logic [DATA_W-1:0] i_master_data,
    output logic              o_master_full,
    output logic [CNT_W-1:0]  o_master_count,
    output logic              o_master_ovf,
    output logic              o_master_valid,
    output logic [DATA_W-1:0] o_master_data,
    input  logic              i_master_ready
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              wr;
    logic              rd;

    // Fullness and validity come from registered occupancy only.
    assign o_master_full  = (cnt == CNT_W'(DEPTH));
    assign o_master_valid = (cnt != '0);
    assign o_master_count = cnt;
    assign o_master_ovf   = ovf;
    assign o_master_data  = mem[rd_ptr];

    assign wr = i_master_en & ~o_master_full;
    assign rd = o_master_valid & i_master_ready;

    // Storage array; cleared on reset so the head reads 0 afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr) begin
            mem[wr_ptr] <= i_master_data;
        end
    end

    // Pointers advance independently and wrap at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: unchanged when a write and a transfer coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wr && !rd) begin
            cnt <= cnt + CNT_W'(1);
        end else if (rd && !wr) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Sticky overflow: a strobe against a full buffer drops the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (i_master_en && o_master_full) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_master_interface.sv
// tb_master_interface: vector table plus scoreboard
// for the master_interface FIFO stage.
module tb_master_interface;

    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rdy = 1'b0;
    logic          full;
    logic [CW-1:0] count;
    logic          ovf;
    logic          valid;
    logic [DW-1:0] dout;

    int n_tests = 0;
    int n_fail = 0;
    int n_xfer = 0;

    logic [DW-1:0] sb_q[$];
    int            m_cnt = 0;
    logic          m_ovf = 1'b0;

    logic          have_prev = 1'b0;
    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    logic [DW-1:0] prev_d = '0;

    typedef struct {
        logic          en;
        logic [DW-1:0] d;
        logic          rdy;
        int            cnt;
        logic          full;
        logic          ovf;
        logic          valid;
    } vec_t;

    vec_t vecs[9];

    master_interface #(
        .DATA_W(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_master_en(en),
        .i_master_data(din),
        .o_master_full(full),
        .o_master_count(count),
        .o_master_ovf(ovf),
        .o_master_valid(valid),
        .o_master_data(dout),
        .i_master_ready(rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transfer monitor: sampled mid-cycle, before the edge that moves data.
    always @(negedge clk) begin
        if (!rst_n) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev && prev_v && !prev_r) begin
                chk("hold_valid", {31'b0, valid}, 32'd1);
                chk("hold_data", dout, prev_d);
            end
            if (valid && rdy) begin
                n_xfer++;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL xfer_unexpected: got %h expected none", dout);
                end else begin
                    chk("xfer_data", dout, sb_q.pop_front());
                end
            end
            have_prev = 1'b1;
            prev_v = valid;
            prev_r = rdy;
            prev_d = dout;
        end
    end

    // One clock: drive, advance the reference model, check outputs.
    task automatic cycle(input logic e, input logic [DW-1:0] d,
                         input logic r);
        int  pre;
        logic w;
        logic t;
        en = e;
        din = d;
        rdy = r;
        @(posedge clk);
        pre = m_cnt;
        w = e && (pre != DEPTH);
        t = r && (pre != 0);
        if (e && pre == DEPTH) m_ovf = 1'b1;
        if (w) sb_q.push_back(d);
        m_cnt = pre + int'(w) - int'(t);
        #1;
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", {31'b0, full}, {31'b0, m_cnt == DEPTH});
        chk("valid", {31'b0, valid}, {31'b0, m_cnt != 0});
        chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int x0;

        vecs[0] = '{1'b1, 32'h10, 1'b0, 1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 32'h11, 1'b0, 2, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'h12, 1'b0, 3, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h13, 1'b0, 4, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h14, 1'b0, 4, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 3, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 32'h0, 1'b1, 2, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 32'h0, 1'b1, 1, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b1, 1'b0};

        // Reset state.
        #12;
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst_data", dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word held under back-pressure, then one transfer.
        cycle(1'b1, 32'hA5A5_0001, 1'b0);
        chk("single_data", dout, 32'hA5A5_0001);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            chk("single_hold", dout, 32'hA5A5_0001);
        end
        x0 = n_xfer;
        cycle(1'b0, 32'h0, 1'b1);
        chk("single_xfer", 32'(n_xfer - x0), 32'd1);
        cycle(1'b0, 32'h0, 1'b1);
        chk("single_xfer_once", 32'(n_xfer - x0), 32'd1);

        // Fill, overflow, drain from the vector table.
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].en, vecs[i].d, vecs[i].rdy);
            chk($sformatf("vec%0d_cnt", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_full", i), {31'b0, full},
                {31'b0, vecs[i].full});
            chk($sformatf("vec%0d_ovf", i), {31'b0, ovf},
                {31'b0, vecs[i].ovf});
            chk($sformatf("vec%0d_valid", i), {31'b0, valid},
                {31'b0, vecs[i].valid});
        end
        chk("drain_empty_sb", 32'(sb_q.size()), 32'd0);

        // Empty with write and ready: accepted, no transfer that cycle.
        x0 = n_xfer;
        cycle(1'b1, 32'h300, 1'b1);
        chk("empty_wr_cnt", 32'(count), 32'd1);
        chk("empty_wr_noxfer", 32'(n_xfer - x0), 32'd0);
        cycle(1'b1, 32'h301, 1'b0);
        cycle(1'b1, 32'h302, 1'b1);
        chk("cnt2_wr_rd", 32'(count), 32'd2);
        cycle(1'b1, 32'h303, 1'b0);
        cycle(1'b1, 32'h304, 1'b0);
        chk("full_again", {31'b0, full}, 32'd1);
        cycle(1'b1, 32'h305, 1'b1);
        chk("full_wr_rd_cnt", 32'(count), 32'd3);
        chk("full_wr_rd_ovf", {31'b0, ovf}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);

        // Asynchronous reset mid-stream with three words buffered.
        cycle(1'b1, 32'h400, 1'b0);
        cycle(1'b1, 32'h401, 1'b0);
        cycle(1'b1, 32'h402, 1'b0);
        chk("pre_rst_cnt", 32'(count), 32'd3);
        en = 1'b0;
        rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, valid}, 32'd0);
        chk("arst_full", {31'b0, full}, 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ovf", {31'b0, ovf}, 32'd0);
        sb_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);

        // Streaming: one transfer per cycle after the first write.
        x0 = n_xfer;
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b1);
        chk("stream_xfers", 32'(n_xfer - x0), 32'd15);
        cycle(1'b0, 32'h0, 1'b1);
        chk("stream_total", 32'(n_xfer - x0), 32'd16);
        chk("stream_ovf", {31'b0, ovf}, 32'd0);

        // Back-pressure with ready pattern 1,0,0,1.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'h200 + 32'(i), (i % 4 == 0) || (i % 4 == 3));
        end
        for (int i = 0; i < 8 && m_cnt != 0; i++) begin
            cycle(1'b0, 32'h0, (i % 4 == 0) || (i % 4 == 3));
        end
        for (int i = 0; i < 8 && m_cnt != 0; i++) cycle(1'b0, 32'h0, 1'b1);
        chk("bp_drained", 32'(count), 32'd0);
        chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/master_interface.md
# master_interface

Transmit-side stage of the valid/ready link. Accepts 32-bit words from a local producer through a single-cycle write strobe and buffers them in a small FIFO. Presents the words to the downstream slave stage on a valid/data/ready handshake, one word per handshake. Decouples producer bursts from slave back-pressure and reports fullness back to the producer.

## Interface
Parameters:
- DATA_W, 32, data word width.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- CNT_W, log2(DEPTH)+1, occupancy counter width; local, derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_master_en  in  1  producer write strobe; one word per high cycle.
- i_master_data  in  DATA_W  producer word; sampled when i_master_en is high.
- o_master_full  out  1  high when occupancy == DEPTH.
- o_master_count  out  CNT_W  current occupancy, 0..DEPTH.
- o_master_ovf  out  1  sticky overflow flag.
- o_master_valid  out  1  head word available to the slave.
- o_master_data  out  DATA_W  head word.
- i_master_ready  in  1  slave can accept a word this cycle.

## Operation
- Storage: DEPTH-entry array, write pointer wr_ptr, read pointer rd_ptr, and occupancy counter cnt; both pointers wrap modulo DEPTH.
- Write accepted (wr) = i_master_en & ~o_master_full. On wr: mem[wr_ptr] ← i_master_data, wr_ptr + 1.
- Transfer (rd) = o_master_valid & i_master_ready. On rd: rd_ptr + 1.
- Counter update:
  - wr & ~rd: cnt + 1.
  - rd & ~wr: cnt − 1.
  - both or neither: cnt unchanged.
- o_master_valid = (cnt != 0); o_master_data = mem[rd_ptr]. Both are derived from registered state only, with no combinational path from i_master_ready or i_master_en.
- Overflow: i_master_en while o_master_full drops the word, with no pointer or counter change, and sets o_master_ovf. This holds even if a transfer occurs in the same cycle, because fullness is judged on the pre-edge state. o_master_ovf clears only on reset.
- Handshake rules:
  - Once o_master_valid is high, it and o_master_data stay stable until the cycle in which i_master_ready is high.
  - i_master_ready high while o_master_valid is low has no effect.
  - Slave ready may arrive in any cycle; no ready-before-valid dependency.
- Underflow is impossible by construction, since rd requires valid.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - cnt = 0, wr_ptr = rd_ptr = 0.
  - o_master_valid = 0, o_master_full = 0, o_master_count = 0, o_master_ovf = 0.
  - o_master_data is don't-care while valid = 0 and reads as 0 after reset (array cleared on reset).
- Latency: a word written at edge N is presented with o_master_valid = 1 after edge N, i.e. one cycle. There is no same-cycle bypass, even when empty with ready high.
- Throughput: one word per cycle sustained when i_master_en and i_master_ready are both continuously high.
- o_master_full and o_master_count update one edge after the causing event.
- Boundary cases:
  - Full with simultaneous write and read: the read completes, the write is dropped, ovf is set, and cnt becomes DEPTH−1.
  - Empty with simultaneous write and ready: the write is accepted, no transfer occurs, and cnt becomes 1.
  - Reset mid-operation discards all buffered words immediately; valid drops asynchronously.

## Test plan
- Reset: assert rst_n = 0 mid-stream with cnt = 3 → valid, full, count and ovf all go to 0 without waiting for a clock edge; buffered words are never presented afterwards.
- Single word: ready = 0, write 0xA5A5_0001 at edge 1 → valid = 1 and data = 0xA5A5_0001 after edge 1; held for 5 cycles; raise ready → one transfer, then valid = 0 and count = 0.
- Fill and overflow: ready = 0, write 0x10, 0x11, 0x12, 0x13 → full = 1, count = 4. Write 0x14 → dropped, ovf = 1, count stays 4. Drain with ready = 1 → 0x10..0x13 presented in order, 0x14 never appears.
- Streaming: ready = 1, write 0x100..0x10F on 16 consecutive cycles → 16 transfers on consecutive cycles starting one cycle after the first write, count never exceeds 1, ovf stays 0.
- Back-pressure: ready alternates 1,0,0,1 with continuous writes 0x200.. → data never changes while valid & ~ready, order is preserved, and count tracks writes minus transfers exactly.
- Simultaneous events:
  - At count 2, write + transfer in the same cycle → count stays 2.
  - At full, write + transfer → count 3 and ovf set.
  - At empty, write + ready → count 1, no transfer that cycle.
